// File: rtl/clk_div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : clk_div_pkg
//  Description : Shared types and constants for the runtime-programmable
//                clock-divider controller.
//                - state_t    : controller FSM state encoding
//                - MIN_PERIOD : smallest legal divide ratio
//  Revision    : 1.0  initial release
// ============================================================================
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } state_t;

    // A period of 1 would need a zero-length low phase; 2 is the shortest
    // period that still produces a real high and a real low phase.
    localparam int MIN_PERIOD = 2;

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : clk_div_ctrl_if
//  Description : Configuration command channel (valid/ready) of the clock
//                divider controller.
//  Signals     : cfg_valid   command valid            (master -> slave)
//                cfg_ready   slave can accept command (slave  -> master)
//                cfg_enable  1 = run, 0 = stop        (master -> slave)
//                cfg_period  clk_in cycles per output period (master -> slave)
//  Revision    : 1.0  initial release
// ============================================================================
interface clk_div_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_enable;
    logic [WIDTH-1:0] cfg_period;

    modport master (
        output cfg_valid,
        output cfg_enable,
        output cfg_period,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_enable,
        input  cfg_period,
        output cfg_ready
    );
endinterface : clk_div_ctrl_if
`default_nettype wire

// File: rtl/clk_div_ctrl_core.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_core
//  Description : Period counter and phase comparator of the clock divider.
//                The counter runs 0..period-1; clk_out is high while the
//                counter is below the high-phase length H = P - floor(P/2).
//  Ports       : clk_in    input clock (rising edge)
//                rst_n     synchronous active-low reset
//                run       divider will be running after this edge
//                load      restart the period at cnt = 0 on this edge
//                period    period currently in effect
//                clk_out   divided clock (registered)
//                tick      registered, high with clk_out while cnt == 0
//                boundary  counter is at the last cycle of the period
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    output logic             clk_out,
    output logic             tick,
    output logic             boundary
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_high;
    logic             r_clk_out;
    logic             r_tick;
    logic             w_clk_nxt;
    logic             w_tick_nxt;

    assign w_high   = period - (period >> 1);
    assign boundary = (r_cnt == (period - c_one));

    // Outputs are computed from the next counter value so that clk_out,
    // tick and the counter always agree within the same cycle. On a load
    // the old period's H is used for the compare, which is harmless: cnt 0
    // is below H for every legal period.
    always_comb begin
        w_cnt_nxt = '0;
        w_clk_nxt = 1'b0;
        if (run) begin
            if (load || boundary) begin
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + c_one;
            end
            w_clk_nxt = (w_cnt_nxt < w_high);
        end
        w_tick_nxt = w_clk_nxt && (w_cnt_nxt == '0);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_clk_out <= w_clk_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;

endmodule : clk_div_core
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_ctrl
//  Description : Runtime-programmable clock-divider controller. Commands
//                (enable, period) arrive over a valid/ready channel; rate
//                changes and stops are applied only at a period boundary so
//                clk_out never shows a runt pulse.
//  Ports       : clk_in      input clock (rising edge)
//                rst_n       synchronous active-low reset
//                cfg         command channel (slave modport)
//                clk_out     divided clock (registered)
//                tick        one-cycle pulse at the start of each period
//                active      divider running
//                cfg_err     one-cycle pulse: illegal period rejected
//                period_cur  period currently in effect
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int DEFAULT_PERIOD = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    clk_div_ctrl_if.slave    cfg,
    output logic             clk_out,
    output logic             tick,
    output logic             active,
    output logic             cfg_err,
    output logic [WIDTH-1:0] period_cur
);

    localparam logic [WIDTH-1:0] c_min_period     = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0] c_default_period = WIDTH'(DEFAULT_PERIOD);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_period_cur;
    logic [WIDTH-1:0] w_period_nxt;
    logic             r_sh_enable;
    logic [WIDTH-1:0] r_sh_period;
    logic             r_cfg_err;

    logic             w_ready;
    logic             w_accept;
    logic             w_illegal;
    logic             w_load;
    logic             w_run;
    logic             w_sh_load;
    logic             w_boundary;

    // The only state that cannot take a command is PENDING: the shadow
    // register is already occupied.
    assign w_ready       = (r_state != PENDING);
    assign cfg.cfg_ready = w_ready;
    assign w_accept      = cfg.cfg_valid && w_ready;
    // A stop command carries no meaningful period, so only enable=1 is
    // checked against the minimum.
    assign w_illegal     = cfg.cfg_enable && (cfg.cfg_period < c_min_period);

    always_comb begin
        w_state_nxt  = r_state;
        w_period_nxt = r_period_cur;
        w_load       = 1'b0;
        w_sh_load    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_illegal && cfg.cfg_enable) begin
                    w_state_nxt  = RUN;
                    w_period_nxt = cfg.cfg_period;
                    w_load       = 1'b1;
                end
            end
            RUN: begin
                if (w_accept && !w_illegal) begin
                    if (w_boundary) begin
                        // Command lands on the boundary edge: apply now,
                        // no detour through PENDING.
                        if (cfg.cfg_enable) begin
                            w_period_nxt = cfg.cfg_period;
                            w_load       = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_state_nxt = PENDING;
                        w_sh_load   = 1'b1;
                    end
                end
            end
            PENDING: begin
                if (w_boundary) begin
                    if (r_sh_enable) begin
                        w_state_nxt  = RUN;
                        w_period_nxt = r_sh_period;
                        w_load       = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The core is told about the state it will be in after this edge, so
    // clk_out drops in the same cycle the controller returns to IDLE.
    assign w_run = (w_state_nxt != IDLE);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_period_cur <= c_default_period;
            r_sh_enable  <= 1'b0;
            r_sh_period  <= '0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_period_cur <= w_period_nxt;
            if (w_sh_load) begin
                r_sh_enable <= cfg.cfg_enable;
                r_sh_period <= cfg.cfg_period;
            end
            r_cfg_err    <= w_accept && w_illegal;
        end
    end

    clk_div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .run      (w_run),
        .load     (w_load),
        .period   (r_period_cur),
        .clk_out  (clk_out),
        .tick     (tick),
        .boundary (w_boundary)
    );

    assign active     = (r_state != IDLE);
    assign cfg_err    = r_cfg_err;
    assign period_cur = r_period_cur;

endmodule : clk_div_ctrl
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_ctrl
//  Description : Directed self-checking bench for clk_div_ctrl. Expected
//                per-cycle outputs {clk_out, tick, active, cfg_ready,
//                cfg_err, period_cur} are queued as each command is driven
//                and popped one per clock, 1 time unit after the rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clk_div_ctrl;

    localparam int WIDTH = 16;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             clk_out;
    logic             tick;
    logic             active;
    logic             cfg_err;
    logic [WIDTH-1:0] period_cur;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH+4:0] exp_q[$];
    string            tag_q[$];

    clk_div_ctrl_if #(.WIDTH(WIDTH)) cfg_bus ();

    clk_div_ctrl #(
        .WIDTH          (WIDTH),
        .DEFAULT_PERIOD (2)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .cfg        (cfg_bus),
        .clk_out    (clk_out),
        .tick       (tick),
        .active     (active),
        .cfg_err    (cfg_err),
        .period_cur (period_cur)
    );

    always #5 clk_in = ~clk_in;

    task automatic push(input string tag, input bit c, input bit t, input bit a,
                        input bit r, input bit e, input int p);
        logic [WIDTH-1:0] pv;
        pv = WIDTH'(p);
        exp_q.push_back({c, t, a, r, e, pv});
        tag_q.push_back(tag);
    endtask

    // Expected running waveform: counter starts at c0, high while cnt < P - P/2.
    task automatic push_run(input string tag, input int p, input int c0,
                            input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            int c;
            bit h;
            c = (c0 + i) % p;
            h = (c < (p - p / 2));
            push($sformatf("%s[%0d]", tag, i), h, h && (c == 0), 1'b1, rdy, 1'b0, p);
        end
    endtask

    task automatic push_idle(input string tag, input int n, input int per);
        for (int i = 0; i < n; i++) begin
            push($sformatf("%s[%0d]", tag, i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, per);
        end
    endtask

    task automatic drive(input bit v, input bit en, input int p);
        cfg_bus.cfg_valid  = v;
        cfg_bus.cfg_enable = en;
        cfg_bus.cfg_period = WIDTH'(p);
    endtask

    task automatic cyc();
        logic [WIDTH+4:0] obs;
        logic [WIDTH+4:0] expv;
        string            tag;
        @(posedge clk_in);
        #1;
        obs = {clk_out, tick, active, cfg_bus.cfg_ready, cfg_err, period_cur};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $error("FAIL no_expectation: observed=%h expected=<none>", obs);
        end else begin
            expv = exp_q.pop_front();
            tag  = tag_q.pop_front();
            assert (obs === expv) else begin
                n_errors++;
                $error("FAIL %s: observed={clk,tick,act,rdy,err,per}=%h expected=%h",
                       tag, obs, expv);
            end
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 0);

        // Reset state
        push_idle("reset", 3, 2);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Start with P=4: 1,1,0,0 repeating, tick every 4
        drive(1'b1, 1'b1, 4);
        push_run("p4", 4, 0, 9, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 0);
        repeat (8) cyc();

        // Walk to cnt=3, then accept P=10 on the boundary edge
        push_run("p4b", 4, 1, 3, 1'b1);
        repeat (3) cyc();
        drive(1'b1, 1'b1, 10);
        push_run("p10", 10, 0, 12, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 0);
        repeat (11) cyc();

        // Mid-period change P=10 -> P=6 through PENDING
        drive(1'b1, 1'b1, 6);
        push_run("p10pend", 10, 2, 8, 1'b0);
        push_run("p6", 6, 0, 1, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 0);
        repeat (8) cyc();

        // Stop at cnt=0: full 1,1,1,0,0,0 then idle
        drive(1'b1, 1'b0, 6);
        push_run("p6stop", 6, 1, 5, 1'b0);
        push_idle("stopped", 3, 6);
        cyc();
        drive(1'b0, 1'b0, 0);
        repeat (7) cyc();

        // P=5, then P=2 at cnt=1: 1,1,1,0,0 then 1,0,1,0
        drive(1'b1, 1'b1, 5);
        push_run("p5", 5, 0, 2, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 0);
        cyc();
        drive(1'b1, 1'b1, 2);
        push_run("p5pend", 5, 2, 3, 1'b0);
        push_run("p2", 2, 0, 4, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 0);
        repeat (6) cyc();

        // Boundary change to P=3, then illegal P=1 while running
        drive(1'b1, 1'b1, 3);
        push_run("p3", 3, 0, 1, 1'b1);
        cyc();
        drive(1'b1, 1'b1, 1);
        push("p3err", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3);
        cyc();
        drive(1'b0, 1'b0, 0);
        push_run("p3after", 3, 2, 5, 1'b1);
        repeat (5) cyc();

        // Reset during PENDING drops the shadow command
        drive(1'b1, 1'b1, 7);
        push_run("p3pend", 3, 1, 1, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 0);
        rst_n = 1'b0;
        push_idle("rstpend", 1, 2);
        cyc();
        rst_n = 1'b1;
        push_idle("postrst", 5, 2);
        repeat (5) cyc();

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_errors++;
            $error("FAIL leftover_expectations: observed=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_clk_div_ctrl
`default_nettype wire
